// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive channel.
// The PARITY state is only reached in builds with UART_RX_PARITY_EN defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   localparam int DEF_BYTESIZES    = 8;
   localparam int DEF_OVERSAMPLING = 16;
   localparam int DEF_SYNC_STAGES  = 2;

   localparam bit PAR_EVEN = 1'b0;
   localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; idles high so
// a reset never looks like a start bit.
module uart_rx_sync
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clock_out,
   input  logic nreset,
   input  logic sdata,
   output logic rxd
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge clock_out or negedge nreset) begin
      if (!nreset) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sdata};
      end
   end

   assign rxd = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver on the oversampled tick clock: start/data/stop framing, one-tick
// valid / frame_error pulses. Define UART_RX_PARITY_EN to add a parity bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BYTESIZES    = DEF_BYTESIZES,
   parameter int OVERSAMPLING = DEF_OVERSAMPLING,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD   = PAR_EVEN
`endif
) (
   input  logic                 clock_out,
   input  logic                 nreset,
   input  logic                 sdata,
   output logic [BYTESIZES-1:0] data,
   output logic                 valid,
   output logic                 frame_error,
   output logic                 parity_error,
   output logic                 busy
);

   localparam int CNT_W = $clog2(OVERSAMPLING);
   localparam int IDX_W = (BYTESIZES > 1) ? $clog2(BYTESIZES) : 1;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLING/2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTESIZES - 1);

   logic                 w_rxd;
   logic                 w_bit_end;
   logic [CNT_W-1:0]     w_cnt_next;
   rx_state_t            r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic [BYTESIZES-1:0] r_shift;
   logic [BYTESIZES-1:0] r_data;
   logic                 r_valid;
   logic                 r_ferr;
   logic                 r_busy;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bad;
   logic                 r_perr;
`endif

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clock_out(clock_out),
      .nreset   (nreset),
      .sdata    (sdata),
      .rxd      (w_rxd)
   );

   // Counter wraps explicitly so non-power-of-two oversampling still works.
   assign w_bit_end  = (r_cnt == CNT_LAST);
   assign w_cnt_next = w_bit_end ? '0 : r_cnt + 1'b1;

   always_ff @(posedge clock_out or negedge nreset) begin
      if (!nreset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad <= 1'b0;
         r_perr    <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr  <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (!w_rxd) begin
                  r_state <= START;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            START: begin
               if (r_cnt == CNT_HALF) begin
                  if (w_rxd) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= DATA;
                     r_cnt   <= '0;
                     r_idx   <= '0;
                  end
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end
            DATA: begin
               r_cnt <= w_cnt_next;
               if (w_bit_end) begin
                  r_shift[r_idx] <= w_rxd;
                  r_idx          <= r_idx + 1'b1;
                  if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               r_cnt <= w_cnt_next;
               if (w_bit_end) begin
                  r_par_bad <= w_rxd ^ (^r_shift) ^ PARITY_ODD;
                  r_state   <= STOP;
               end
            end
`endif
            STOP: begin
               r_cnt <= w_cnt_next;
               if (w_bit_end) begin
                  if (w_rxd) begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     r_perr  <= r_par_bad;
`endif
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= BREAK;
                  end
               end
            end
            BREAK: begin
               // A held-low line must return high before a new start is armed.
               if (w_rxd) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data        = r_data;
   assign valid       = r_valid;
   assign frame_error = r_ferr;
   assign busy        = r_busy;
`ifdef UART_RX_PARITY_EN
   assign parity_error = r_perr;
`else
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are generated at the nominal
// bit rate and the expected output events come from a frame-level model.
module tb_uart_rx;

   localparam int B  = 8;
   localparam int OS = 16;
   localparam int SS = 2;
`ifdef UART_RX_PARITY_EN
   localparam int NPAR = 1;
`else
   localparam int NPAR = 0;
`endif
   localparam bit PODD = 1'b0;
   // drive of start bit -> valid visible: sync delay, IDLE detect, half bit, full bits
   localparam int LAT = SS + 1 + OS/2 + (B + 1 + NPAR) * OS;

   logic         clock_out = 1'b0;
   logic         nreset    = 1'b0;
   logic         sdata     = 1'b1;
   logic [B-1:0] data;
   logic         valid;
   logic         frame_error;
   logic         parity_error;
   logic         busy;

   uart_rx #(
      .BYTESIZES   (B),
      .OVERSAMPLING(OS),
      .SYNC_STAGES (SS)
   ) dut (
      .clock_out   (clock_out),
      .nreset      (nreset),
      .sdata       (sdata),
      .data        (data),
      .valid       (valid),
      .frame_error (frame_error),
      .parity_error(parity_error),
      .busy        (busy)
   );

   always #5 clock_out = ~clock_out;

   int cyc = 0;
   always @(posedge clock_out) cyc <= cyc + 1;

   typedef struct {
      logic [B-1:0] d;
      logic         v;
      logic         fe;
      logic         pe;
      int           t;
   } ev_t;

   ev_t obs[$];
   ev_t exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;
   logic [B-1:0] last_good = '0;

   always @(negedge clock_out) begin
      if (nreset && (valid || frame_error || parity_error))
         obs.push_back('{data, valid, frame_error, parity_error, cyc});
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   function automatic logic par_of(input logic [B-1:0] b);
      return (^b) ^ PODD;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clock_out);
   endtask

   task automatic send_frame(input logic [B-1:0] b, input logic stop, input logic par,
                             output int t0);
      sdata = 1'b0;
      t0    = cyc;
      tick(OS);
      for (int i = 0; i < B; i++) begin
         sdata = b[i];
         tick(OS);
      end
`ifdef UART_RX_PARITY_EN
      sdata = par;
      tick(OS);
`else
      sdata = sdata | (par & 1'b0);
`endif
      sdata = stop;
      tick(OS);
   endtask

   // Frame-level model: a good stop bit delivers the byte (with its parity
   // verdict), a bad one raises frame_error and leaves data alone.
   task automatic model_frame(input logic [B-1:0] b, input logic stop, input logic par,
                              input int t0);
      ev_t e;
      if (stop) begin
         e.d  = b;
         e.v  = 1'b1;
         e.fe = 1'b0;
         e.pe = (NPAR == 1) ? (par != par_of(b)) : 1'b0;
         last_good = b;
      end else begin
         e.d  = last_good;
         e.v  = 1'b0;
         e.fe = 1'b1;
         e.pe = 1'b0;
      end
      e.t = t0 + LAT;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      tick(3);
      n_cmp++; if (data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", data); end
      n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
      n_cmp++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_error); end
      n_cmp++; if (parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_error); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      nreset = 1'b1;
      tick(4);
   endtask

   task automatic test_basic();
      int t0;
      obs.delete();
      send_frame(8'hA5, 1'b1, par_of(8'hA5), t0);
      last_good = 8'hA5;
      tick(4);
      n_cmp++; if (obs.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d pulses want 1", obs.size()); end
      if (obs.size() >= 1) begin
         n_cmp++; if (obs[0].d !== 8'hA5 || obs[0].v !== 1'b1) begin n_fail++; $display("FAIL basic_data: got %0h v=%b want a5 v=1", obs[0].d, obs[0].v); end
         n_cmp++; if (obs[0].fe !== 1'b0 || obs[0].pe !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got fe=%b pe=%b want 0 0", obs[0].fe, obs[0].pe); end
         n_cmp++; if (obs[0].t !== t0 + LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", obs[0].t - t0, LAT); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
      n_cmp++; if (data !== 8'hA5) begin n_fail++; $display("FAIL basic_hold: got %0h want a5", data); end
   endtask

   task automatic test_glitch();
      obs.delete();
      sdata = 1'b0;
      tick(6);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
      sdata = 1'b1;
      tick(40);
      n_cmp++; if (obs.size() !== 0) begin n_fail++; $display("FAIL glitch_events: got %0d pulses want 0", obs.size()); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got busy %b want 0", busy); end
      n_cmp++; if (data !== last_good) begin n_fail++; $display("FAIL glitch_data: got %0h want %0h", data, last_good); end
   endtask

   task automatic test_frame_error();
      int t0, t1;
      logic [B-1:0] prev;
      obs.delete();
      prev = last_good;
      send_frame(8'h3C, 1'b0, par_of(8'h3C), t0);
      tick(40);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
      sdata = 1'b1;
      tick(OS);
      send_frame(8'h81, 1'b1, par_of(8'h81), t1);
      last_good = 8'h81;
      tick(4);
      n_cmp++; if (obs.size() !== 2) begin n_fail++; $display("FAIL ferr_count: got %0d pulses want 2", obs.size()); end
      if (obs.size() >= 2) begin
         n_cmp++; if (obs[0].fe !== 1'b1 || obs[0].v !== 1'b0 || obs[0].pe !== 1'b0) begin n_fail++; $display("FAIL ferr_flags: got fe=%b v=%b pe=%b want 1 0 0", obs[0].fe, obs[0].v, obs[0].pe); end
         n_cmp++; if (obs[0].d !== prev) begin n_fail++; $display("FAIL ferr_data_kept: got %0h want %0h", obs[0].d, prev); end
         n_cmp++; if (obs[0].t !== t0 + LAT) begin n_fail++; $display("FAIL ferr_time: got %0d want %0d", obs[0].t - t0, LAT); end
         n_cmp++; if (obs[1].d !== 8'h81 || obs[1].v !== 1'b1 || obs[1].fe !== 1'b0) begin n_fail++; $display("FAIL ferr_next: got %0h v=%b fe=%b want 81 1 0", obs[1].d, obs[1].v, obs[1].fe); end
      end
   endtask

   task automatic test_back_to_back();
      logic [B-1:0] bytes[$];
      int t0;
      obs.delete();
      exp_q.delete();
      bytes = '{8'h00, 8'hFF, 8'h55};
      for (int i = 0; i < 5; i++) bytes.push_back(B'($urandom));
      foreach (bytes[i]) begin
         send_frame(bytes[i], 1'b1, par_of(bytes[i]), t0);
         model_frame(bytes[i], 1'b1, par_of(bytes[i]), t0);
      end
      tick(4);
      n_cmp++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d pulses want %0d", obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         n_cmp++;
         if ({obs[i].d, obs[i].v, obs[i].fe, obs[i].pe} !== {exp_q[i].d, exp_q[i].v, exp_q[i].fe, exp_q[i].pe} || obs[i].t !== exp_q[i].t) begin
            n_fail++;
            $display("FAIL b2b_frame%0d: got d=%0h v=%b fe=%b pe=%b t=%0d want d=%0h v=%b fe=%b pe=%b t=%0d", i,
                     obs[i].d, obs[i].v, obs[i].fe, obs[i].pe, obs[i].t, exp_q[i].d, exp_q[i].v, exp_q[i].fe, exp_q[i].pe, exp_q[i].t);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [B-1:0] part;
      int t0;
      obs.delete();
      part  = 8'h0F;
      sdata = 1'b0;
      tick(OS);
      for (int i = 0; i < 4; i++) begin
         sdata = part[i];
         tick(OS);
      end
      sdata = part[4];
      tick(OS/2);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
      nreset = 1'b0;
      tick(2);
      n_cmp++; if ({data, valid, frame_error, parity_error, busy} !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got d=%0h v=%b fe=%b pe=%b busy=%b want all 0", data, valid, frame_error, parity_error, busy); end
      sdata = 1'b1;
      tick(OS);
      nreset    = 1'b1;
      last_good = '0;
      tick(OS);
      send_frame(8'h5A, 1'b1, par_of(8'h5A), t0);
      last_good = 8'h5A;
      tick(4);
      n_cmp++; if (obs.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d pulses want 1", obs.size()); end
      if (obs.size() >= 1) begin
         n_cmp++; if (obs[0].d !== 8'h5A || obs[0].v !== 1'b1 || obs[0].fe !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame: got %0h v=%b fe=%b want 5a 1 0", obs[0].d, obs[0].v, obs[0].fe); end
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int t0;
      obs.delete();
      send_frame(8'h07, 1'b1, 1'b0, t0);
      tick(2);
      send_frame(8'h07, 1'b1, 1'b1, t0);
      last_good = 8'h07;
      tick(4);
      n_cmp++; if (obs.size() !== 2) begin n_fail++; $display("FAIL parity_count: got %0d pulses want 2", obs.size()); end
      if (obs.size() >= 2) begin
         n_cmp++; if (obs[0].v !== 1'b1 || obs[0].pe !== 1'b1 || obs[0].d !== 8'h07) begin n_fail++; $display("FAIL parity_bad: got v=%b pe=%b d=%0h want 1 1 07", obs[0].v, obs[0].pe, obs[0].d); end
         n_cmp++; if (obs[1].v !== 1'b1 || obs[1].pe !== 1'b0 || obs[1].d !== 8'h07) begin n_fail++; $display("FAIL parity_good: got v=%b pe=%b d=%0h want 1 0 07", obs[1].v, obs[1].pe, obs[1].d); end
      end
   endtask
`endif

   task automatic test_random();
      logic [B-1:0] b;
      logic         stop;
      logic         par;
      int           t0;
      obs.delete();
      exp_q.delete();
      for (int n = 0; n < 30; n++) begin
         b    = B'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         par  = par_of(b) ^ ((NPAR == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
         send_frame(b, stop, par, t0);
         model_frame(b, stop, par, t0);
         if (!stop) begin
            tick($urandom_range(1, 40));
            sdata = 1'b1;
            tick($urandom_range(OS, 2 * OS));
         end else begin
            tick($urandom_range(0, 20));
         end
      end
      tick(4);
      n_cmp++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d pulses want %0d", obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         n_cmp++;
         if ({obs[i].d, obs[i].v, obs[i].fe, obs[i].pe} !== {exp_q[i].d, exp_q[i].v, exp_q[i].fe, exp_q[i].pe} || obs[i].t !== exp_q[i].t) begin
            n_fail++;
            $display("FAIL rand_frame%0d: got d=%0h v=%b fe=%b pe=%b t=%0d want d=%0h v=%b fe=%b pe=%b t=%0d", i,
                     obs[i].d, obs[i].v, obs[i].fe, obs[i].pe, obs[i].t, exp_q[i].d, exp_q[i].v, exp_q[i].fe, exp_q[i].pe, exp_q[i].t);
         end
      end
      n_cmp++; if (data !== last_good) begin n_fail++; $display("FAIL rand_final_data: got %0h want %0h", data, last_good); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_error();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive channel: recovers serial frames from `sdata` and presents parallel bytes with a one-cycle `valid` strobe. It runs on the oversampled tick clock `clock_out` produced by the baud-rate generator at BAUDRATE×OVERSAMPLING. It is the receiving end of the UART link.
- Frame format: idle high, one start bit (0), BYTESIZES data bits LSB first, one stop bit (1).

Parameters:
- BYTESIZES, 8: data bits per frame.
- OVERSAMPLING, 16: `clock_out` ticks per bit. Must be even and ≥4.
- SYNC_STAGES, 2: flip-flops in the `sdata` synchronizer. Must be ≥2.

Ports:
- clock_out  input  1  oversampled bit clock; all logic on posedge.
- nreset  input  1  asynchronous, active-low reset.
- sdata  input  1  serial line, asynchronous to `clock_out`.
- data  output  BYTESIZES  last correctly received byte.
- valid  output  1  one-cycle pulse when `data` is updated.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled as 0.
- parity_error  output  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset values (asynchronous on `nreset`=0):
  - all synchronizer stages = 1
  - state = IDLE, tick counter = 0, bit index = 0, shift register = 0
  - `data` = 0; `valid`, `frame_error`, `parity_error`, `busy` = 0
- Synchronizer output `rxd` is `sdata` delayed by SYNC_STAGES ticks. Only `rxd` is used downstream.
- Tick counter: width clog2(OVERSAMPLING), counts 0..OVERSAMPLING-1 and wraps.
- States:
  - IDLE: when `rxd`=0, go to START and clear the counter.
  - START: at counter = OVERSAMPLING/2-1 (bit centre), re-sample `rxd`.
    - `rxd`=1: false start; return to IDLE with no flags.
    - `rxd`=0: clear counter, clear bit index, go to DATA.
  - DATA: at counter = OVERSAMPLING-1, shift `rxd` into bit[index] (LSB first), then increment index.
    - After bit BYTESIZES-1, go to PARITY if enabled, else STOP.
  - PARITY (macro only): sample at counter = OVERSAMPLING-1, compare, then go to STOP.
  - STOP: sample at counter = OVERSAMPLING-1.
    - `rxd`=1: load `data` from the shift register and pulse `valid`; go to IDLE.
    - `rxd`=0: pulse `frame_error`; `data` is not updated; go to BREAK.
  - BREAK: wait until `rxd`=1, then go to IDLE. No new start is detected while `rxd` stays low.
- Latency: the stop-bit sample occurs OVERSAMPLING/2 + (BYTESIZES+1)×OVERSAMPLING ticks after the IDLE→START transition (+OVERSAMPLING with parity). `valid` is high on the tick immediately after that sample.
- Output pulses: `valid`, `frame_error` and `parity_error` are exactly one tick wide.
  - `valid` and `frame_error` are never high together.
  - A parity error still delivers the byte: `valid` and `parity_error` pulse together.
- Back-to-back frames: a new start bit is accepted in IDLE on the tick after the stop sample. A zero-gap frame that starts mid-stop-bit is therefore received correctly.
- `data` holds its value between frames.
- Reset mid-frame aborts the frame immediately. No flags are raised and `data` keeps its reset value 0.
- No receive FIFO. A consumer must take `data` before the next `valid`, i.e. within one frame time.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is compiled in; one parity bit follows the data bits.
  - Parity sense is set by parameter PARITY_ODD (default 0 = even).
  - Received parity must equal the XOR of the data bits, XOR PARITY_ODD.
  - A mismatch pulses `parity_error` together with `valid`.
- Undefined:
  - No PARITY state and no PARITY_ODD parameter.
  - `parity_error` is driven constant 0.
  - Frame is start + data + stop.

Decomposition:
- Package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, PARITY, STOP, BREAK}
  - default BYTESIZES/OVERSAMPLING constants
  - parity-sense constants
- One sub-module `uart_rx_sync`: parameterized SYNC_STAGES-deep synchronizer, reset to 1, output `rxd`.

Test Plan (BYTESIZES=8, OVERSAMPLING=16):
- Send 0xA5 at the nominal bit rate → one `valid` pulse, `data`=0xA5, `frame_error`=0, `busy` low afterward.
- Low glitch of 6 ticks on idle `sdata` → no `valid` and no `frame_error`; state returns to IDLE; `data` unchanged.
- Send 0x3C with stop bit forced to 0 and the line held low 40 ticks → `frame_error` pulses once; `data` keeps its previous value; next frame 0x81 is received correctly.
- Back-to-back 0x00, 0xFF, 0x55 with zero idle gap → three `valid` pulses in order with matching `data`.
- Assert `nreset` during data bit 4 of a frame, release, then send 0x5A → all outputs 0 during reset; only 0x5A is reported.
- With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 → `valid` plus `parity_error` pulse; with parity bit 1 → `valid` only.
